// File: rtl/bin_bcd_encoder.sv
// bin_bcd_encoder: sequential binary-to-BCD converter. It uses the
// shift-and-add-3 (double-dabble) method and consumes one input bit per clock.
// The result saturates to all nines when the value does not fit in DIGITS
// decimal digits.
// Optional feature: define LEADING_BLANK_EN to blank leading zero digits.
// A blanked digit is output as 4'd10, which the display decoders show as blank.
module bin_bcd_encoder #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      binary,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [DIGITS*4-1:0]   bcd,
   output logic                  ovf
);

   // Decimal digits needed for 2^WIDTH-1 (log10(2) ~ 0.301), never fewer than DIGITS
   localparam int SDIG_RAW = (WIDTH * 301) / 1000 + 1;
   localparam int SDIG     = (SDIG_RAW > DIGITS) ? SDIG_RAW : DIGITS;
   localparam int SW       = SDIG * 4;
   localparam int CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);

   // Reset pattern of the display: digit 0 shows 0, upper digits blank when enabled
   function automatic logic [DIGITS*4-1:0] reset_bcd();
      logic [DIGITS*4-1:0] v;
      v = '0;
`ifdef LEADING_BLANK_EN
      for (int k = 1; k < DIGITS; k++) begin
         v[4*k +: 4] = 4'd10;
      end
`endif
      return v;
   endfunction

   localparam logic [DIGITS*4-1:0] BCD_RST = reset_bcd();

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      shift_q, shift_d;
   logic [SW-1:0]         scratch_q, scratch_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DIGITS*4-1:0]   bcd_q, bcd_d;
   logic                  ovf_q, ovf_d;
   logic                  done_q, done_d;

   logic [SW-1:0]         adj;
   logic [SW+WIDTH-1:0]   shifted_all;
   logic [SW-1:0]         shifted_scratch;
   logic [WIDTH-1:0]      shifted_bin;
   logic                  upper_nonzero;
   logic [DIGITS*4-1:0]   disp;
`ifdef LEADING_BLANK_EN
   logic                  nz_seen;
`endif

   // Next-state logic: one double-dabble step per SHIFT cycle, result load on the last
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      count_d   = count_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;

      adj = scratch_q;
      for (int k = 0; k < SDIG; k++) begin
         if (scratch_q[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
         end
      end
      shifted_all     = {adj, shift_q} << 1;
      shifted_scratch = shifted_all[SW+WIDTH-1:WIDTH];
      shifted_bin     = shifted_all[WIDTH-1:0];

      upper_nonzero = 1'b0;
      for (int k = 0; k < SDIG; k++) begin
         if (k >= DIGITS && shifted_scratch[4*k +: 4] != 4'd0) begin
            upper_nonzero = 1'b1;
         end
      end

      disp = shifted_scratch[DIGITS*4-1:0];
`ifdef LEADING_BLANK_EN
      nz_seen = 1'b0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         if (disp[4*k +: 4] != 4'd0) begin
            nz_seen = 1'b1;
         end else if (!nz_seen) begin
            disp[4*k +: 4] = 4'd10;
         end
      end
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               shift_d   = binary;
               scratch_d = '0;
               count_d   = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            scratch_d = shifted_scratch;
            shift_d   = shifted_bin;
            count_d   = count_q + 1'b1;
            if (count_q == LAST_SHIFT) begin
               state_d = IDLE;
               done_d  = 1'b1;
               ovf_d   = upper_nonzero;
               bcd_d   = upper_nonzero ? {DIGITS{4'h9}} : disp;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously by the active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         count_q   <= '0;
         bcd_q     <= BCD_RST;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         count_q   <= count_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = done_q;
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_bcd_encoder.sv
// Directed self-checking bench for bin_bcd_encoder.
// Instance A: WIDTH=8, DIGITS=3. Instance B: WIDTH=8, DIGITS=2.
// The expected display values follow LEADING_BLANK_EN.
module tb_bin_bcd_encoder;

   // Blank code for leading zero digits in this build
`ifdef LEADING_BLANK_EN
   localparam logic [3:0] Z = 4'hA;
`else
   localparam logic [3:0] Z = 4'h0;
`endif
   localparam logic [11:0] RST_A = {Z, Z, 4'h0};

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  binaryA, binaryB;
   logic        startA, startB;
   logic        busyA, doneA, ovfA;
   logic        busyB, doneB, ovfB;
   logic [11:0] bcdA;
   logic [7:0]  bcdB;

   int          compareCount = 0;
   int          mismatchCount = 0;
   logic [11:0] lastBcdA;

   bin_bcd_encoder #(.WIDTH(8), .DIGITS(3)) dutA (
      .clk(clk), .reset(reset), .binary(binaryA), .start(startA),
      .busy(busyA), .done(doneA), .bcd(bcdA), .ovf(ovfA)
   );

   bin_bcd_encoder #(.WIDTH(8), .DIGITS(2)) dutB (
      .clk(clk), .reset(reset), .binary(binaryB), .start(startB),
      .busy(busyB), .done(doneB), .bcd(bcdB), .ovf(ovfB)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // Counts one comparison and reports it if the observed value differs
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Accepts a start on the next edge (edge N) and returns #1 after it
   task automatic applyStimulus(input logic [7:0] value);
      binaryA = value;
      startA  = 1'b1;
      @(posedge clk);
      #1;
      startA  = 1'b0;
      binaryA = 8'h00;
   endtask

   // Full conversion on instance A. An optional stray start arrives at edge N+pulseAt.
   task automatic convertA(input string tag, input logic [7:0] value,
                           input logic [11:0] expBcd, input logic expOvf,
                           input int pulseAt);
      applyStimulus(value);
      checkOutput({tag, " busy@N"}, busyA, 1);
      for (int i = 1; i <= 8; i++) begin
         if (i == pulseAt) begin
            startA  = 1'b1;
            binaryA = 8'd5;
         end
         @(posedge clk);
         #1;
         startA  = 1'b0;
         binaryA = 8'h00;
         if (i == 4) checkOutput({tag, " bcd held"}, bcdA, lastBcdA);
         if (i == 7) begin
            checkOutput({tag, " busy@N+7"}, busyA, 1);
            checkOutput({tag, " no early done"}, doneA, 0);
         end
      end
      checkOutput({tag, " done"}, doneA, 1);
      checkOutput({tag, " busy low"}, busyA, 0);
      checkOutput({tag, " bcd"}, bcdA, expBcd);
      checkOutput({tag, " ovf"}, ovfA, expOvf);
      lastBcdA = expBcd;
      @(posedge clk);
      #1;
      checkOutput({tag, " done 1 cycle"}, doneA, 0);
      checkOutput({tag, " bcd kept"}, bcdA, expBcd);
   endtask

   // Full conversion on instance B (two digits)
   task automatic convertB(input string tag, input logic [7:0] value,
                           input logic [7:0] expBcd, input logic expOvf);
      binaryB = value;
      startB  = 1'b1;
      @(posedge clk);
      #1;
      startB = 1'b0;
      repeat (7) @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput({tag, " done"}, doneB, 1);
      checkOutput({tag, " bcd"}, bcdB, expBcd);
      checkOutput({tag, " ovf"}, ovfB, expOvf);
   endtask

   initial begin
      reset   = 1'b0;
      binaryA = 8'h00;
      binaryB = 8'h00;
      startA  = 1'b0;
      startB  = 1'b0;
      lastBcdA = RST_A;

      #12;
      checkOutput("rst busy", busyA, 0);
      checkOutput("rst done", doneA, 0);
      checkOutput("rst ovf", ovfA, 0);
      checkOutput("rst bcd", bcdA, RST_A);
      checkOutput("rst bcdB", bcdB, {Z, 4'h0});
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Main conversions and display patterns
      convertA("v255", 8'd255, 12'h255, 1'b0, 0);
      convertA("v0",   8'd0,   {Z, Z, 4'h0}, 1'b0, 0);
      convertA("v7",   8'd7,   {Z, Z, 4'h7}, 1'b0, 0);
      convertA("v100", 8'd100, 12'h100, 1'b0, 0);
      convertA("v42",  8'd42,  {Z, 4'h4, 4'h2}, 1'b0, 0);

      // A start that arrives while busy must not disturb the conversion
      convertA("v200 ignore", 8'd200, 12'h200, 1'b0, 3);

      // Overflow saturation and recovery on the two-digit instance
      convertB("B150", 8'd150, 8'h99, 1'b1);
      convertB("B42",  8'd42,  8'h42, 1'b0);
      convertB("B5",   8'd5,   {Z, 4'h5}, 1'b0);
      convertB("B99",  8'd99,  8'h99, 1'b0);

      // Back-to-back conversions with start held high
      binaryA = 8'd13;
      startA  = 1'b1;
      @(posedge clk);
      #1;
      repeat (7) @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("b2b done13", doneA, 1);
      checkOutput("b2b bcd13", bcdA, {Z, 4'h1, 4'h3});
      binaryA = 8'd14;
      @(posedge clk);
      #1;
      checkOutput("b2b reaccept", busyA, 1);
      checkOutput("b2b done gap", doneA, 0);
      repeat (7) @(posedge clk);
      @(posedge clk);
      #1;
      startA = 1'b0;
      checkOutput("b2b done14", doneA, 1);
      checkOutput("b2b bcd14", bcdA, {Z, 4'h1, 4'h4});
      @(posedge clk);
      #1;
      checkOutput("b2b stop", busyA, 0);
      lastBcdA = {Z, 4'h1, 4'h4};

      // Reset in the middle of a conversion aborts it
      applyStimulus(8'd99);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("abort busy", busyA, 0);
      checkOutput("abort done", doneA, 0);
      checkOutput("abort bcd", bcdA, RST_A);
      repeat (8) @(posedge clk);
      #1;
      checkOutput("abort no done", doneA, 0);
      checkOutput("abort bcd kept", bcdA, RST_A);
      @(negedge clk);
      reset = 1'b1;
      lastBcdA = RST_A;
      @(posedge clk);
      #1;
      convertA("v99 after rst", 8'd99, {Z, 4'h9, 4'h9}, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
